// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT,
    RESP
  } memctrl_state_t;

  localparam int BEATS_WORD = 4;
  localparam int BYTE_W     = 8;

endpackage

// File: rtl/data_mem_ctrl.sv
// Load/store controller: serialises lb/lw/sb/sw onto a byte-wide synchronous RAM,
// little-endian, with a one-cycle response pulse and sign-extended byte loads.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_word_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i
);

  memctrl_state_t        state_q, state_d;
  logic [1:0]            beat_q;
  logic                  we_q, word_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [23:0]           lanes_q;
  logic [31:0]           rdata_q;

  logic       accept;
  logic       misaligned;
  logic [1:0] last_beat;
  logic       in_run;

  assign accept     = req_valid_i && (state_q == IDLE);
  assign misaligned = req_word_i && (req_addr_i[1:0] != 2'b00);
  assign last_beat  = word_q ? 2'(BEATS_WORD - 1) : 2'd0;
  assign in_run     = (state_q == RUN);

  // NOTE: the state register is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: defaulting state_d first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = misaligned ? RESP : RUN;
      RUN:  if (beat_q == last_beat) state_d = we_q ? RESP : CAPT;
      CAPT: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_q  <= '0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lanes_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          we_q    <= req_we_i;
          word_q  <= req_word_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          err_q   <= misaligned;
          beat_q  <= '0;
        end
        RUN: begin
          // Read data lags its address by one cycle, so beat k lands lane k-1.
          if (!we_q) begin
            unique case (beat_q)
              2'd1:    lanes_q[7:0]   <= ram_rdata_i;
              2'd2:    lanes_q[15:8]  <= ram_rdata_i;
              2'd3:    lanes_q[23:16] <= ram_rdata_i;
              default: ;
            endcase
          end
          if (beat_q != last_beat) beat_q <= beat_q + 2'd1;
        end
        CAPT: rdata_q <= word_q ? {ram_rdata_i, lanes_q}
                                : {{24{ram_rdata_i[BYTE_W-1]}}, ram_rdata_i};
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign stall_o     = !req_ready_o;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = (state_q == RESP) && err_q;
  assign rdata_o     = rdata_q;

  // RAM strobes decode straight from state, so an async reset drops them at once.
  assign ram_we_o    = in_run && we_q;
  assign ram_addr_o  = in_run ? addr_q + ADDR_WIDTH'(beat_q) : '0;
  assign ram_wdata_o = in_run ? wdata_q[BYTE_W*beat_q +: BYTE_W] : '0;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory controller that executes the load/store requests the decode stage issues (lb, lw, sb, sw) against a byte-wide synchronous RAM. It sits between the execute stage (ALU result as address, rs2 as store data, memWrite/addrSelect as request type) and the data RAM. It serialises word accesses into four little-endian byte beats and returns sign-extended load data with a one-cycle response pulse. `stall_o` freezes the pipeline while an access is in flight.

## Interface
- `ADDR_WIDTH`, default 17: byte-address width of the RAM.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present; held stable by the requester until accepted.
- `req_ready_o` out 1: controller idle; a request is accepted when valid and ready are both high.
- `req_we_i` in 1: 1 = store, 0 = load (memWrite enable).
- `req_word_i` in 1: 1 = word access, 0 = byte access (addrSelect).
- `req_addr_i` in ADDR_WIDTH: byte address.
- `req_wdata_i` in 32: store data; a byte store uses bits [7:0].
- `rsp_valid_o` out 1: one-cycle pulse when the access completes.
- `rsp_err_o` out 1: valid with `rsp_valid_o`; 1 = misaligned word access.
- `rdata_o` out 32: load result, held until the next response.
- `stall_o` out 1: equals `!req_ready_o`.
- `ram_addr_o` out ADDR_WIDTH: RAM byte address.
- `ram_we_o` out 1: RAM write strobe.
- `ram_wdata_o` out 8: RAM write byte.
- `ram_rdata_i` in 8: RAM read byte, valid one cycle after its address is presented.

## Operation
- States: IDLE, RUN, CAPT, RESP.
- IDLE
  - `req_ready_o` = 1.
  - On handshake, latch we, word, addr and wdata, and clear the beat counter.
  - Misaligned word request (word=1, addr[1:0] ≠ 0): go to RESP with err = 1; no RAM access.
  - Otherwise go to RUN.
- RUN, beat k (k = 0 for byte; 0..3 for word)
  - `ram_addr_o` = addr + k.
  - `ram_we_o` = we.
  - `ram_wdata_o` = wdata[8k+7:8k].
  - On loads, when k > 0, capture `ram_rdata_i` into byte lane k−1.
  - After the last beat: stores go to RESP, loads go to CAPT.
- CAPT: capture `ram_rdata_i` into the final lane; go to RESP.
- RESP
  - `rsp_valid_o` = 1.
  - Loads update `rdata_o`: a word is the assembled 32 bits (lane 0 = lowest address); a byte is sign-extended from bit 7 (lb).
  - Stores and errors leave `rdata_o` unchanged.
  - Go to IDLE.
- Outside RUN: `ram_we_o` = 0; `ram_addr_o` and `ram_wdata_o` are don't-care, driven as 0.
- RAM signals are decoded combinationally from state and the beat counter, so reset removes `ram_we_o` asynchronously.
- Aligned words never cross the top of the address space; addr + k is computed modulo 2^ADDR_WIDTH.

## Timing
- Request accepted in cycle T.
- `rsp_valid_o` occurs at:
  - misaligned word: T+1
  - sb: T+2
  - lb: T+3
  - sw: T+5
  - lw: T+6
- No back-to-back acceptance: `req_ready_o` = 0 from T+1 through the RESP cycle, and is high again the cycle after RESP.
- `req_valid_i` while busy is ignored; the requester holds the request.
- Reset values:
  - state = IDLE
  - `req_ready_o` = 1
  - `stall_o` = 0
  - `rsp_valid_o`, `rsp_err_o`, `ram_we_o` = 0
  - `rdata_o`, `ram_addr_o`, `ram_wdata_o` = 0
  - beat counter = 0
- Reset mid-operation aborts the access immediately and no response is produced. Bytes of a word store already written stay written; this is accepted behaviour.

## Structure
- Shared package `mem_pkg`:
  - state enum `memctrl_state_t` {IDLE, RUN, CAPT, RESP}
  - constant `BEATS_WORD` = 4
  - constant `BYTE_W` = 8
- Single module with no sub-module. Lane assembly and sign extension are a few lines inline.
- The beat counter is 2 bits.

## Test plan
- Reset with `rst_n_i` low mid-RUN of an sw → `ram_we_o` drops in the same cycle; after release, state is IDLE, `req_ready_o` = 1, no `rsp_valid_o`.
- sw addr 0x100 data 0xDEADBEEF → RAM writes EF, BE, AD, DE to 0x100..0x103 on T+1..T+4; `rsp_valid_o` at T+5 with err = 0.
- lw addr 0x100 (RAM holds the bytes above) → `rdata_o` = 0xDEADBEEF, `rsp_valid_o` at T+6; `stall_o` high T+1..T+6.
- lb addr 0x103 → `rdata_o` = 0xFFFFFFDE; lb of byte 0x7F → 0x0000007F; `rsp_valid_o` at T+3.
- sb addr 0x001 data 0x12345678 → single write of 0x78 at 0x001 on T+1; neighbouring bytes unchanged.
- lw addr 0x102 → `rsp_valid_o` and `rsp_err_o` at T+1, `ram_we_o` never asserted, `rdata_o` unchanged; a `req_valid_i` held during the busy cycles is accepted only once `req_ready_o` returns.
